// File: rtl/branch_predictor_pkg.sv
// ============================================================
// branch_predictor_pkg : shared types and helpers for the BTB predictor
// Revision: 1.0
// ============================================================
`default_nettype none

package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int DEF_IDX_W = 4;

  // Two-bit saturating counter step toward the resolved direction
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_btb_table.sv
// ============================================================
// branch_predictor_btb_table : direct-mapped BTB storage with a lookup port
//                              and a read-modify-write update port
// Revision: 1.0
// ============================================================
`default_nettype none

module branch_predictor_btb_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = 26,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_raddr,
  output logic             o_rvalid,
  output logic [TAG_W-1:0] o_rtag,
  output logic [XLEN-1:0]  o_rtarget,
  output logic [1:0]       o_rctr,
  input  logic [IDX_W-1:0] i_uaddr,
  output logic             o_uvalid,
  output logic [TAG_W-1:0] o_utag,
  output logic [1:0]       o_uctr,
  input  logic             i_we,
  input  logic             i_wvalid,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic             i_wtgt_en,
  input  logic [XLEN-1:0]  i_wtarget,
  input  logic [1:0]       i_wctr
);

  localparam int DEPTH = 2 ** IDX_W;

  logic             r_valid  [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];

  assign o_rvalid  = r_valid[i_raddr];
  assign o_rtag    = r_tag[i_raddr];
  assign o_rtarget = r_target[i_raddr];
  assign o_rctr    = r_ctr[i_raddr];

  assign o_uvalid  = r_valid[i_uaddr];
  assign o_utag    = r_tag[i_uaddr];
  assign o_uctr    = r_ctr[i_uaddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= WNT;
      end
    end else if (i_we) begin
      r_valid[i_uaddr] <= i_wvalid;
      r_tag[i_uaddr]   <= i_wtag;
      r_ctr[i_uaddr]   <= i_wctr;
      if (i_wtgt_en) r_target[i_uaddr] <= i_wtarget;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================
// branch_predictor : fetch-side BTB + 2-bit counter prediction with
//                    execute-side training and misprediction detection
// Revision: 1.0
// ============================================================
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int XLEN  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     MispredCount
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic [IDX_W-1:0] w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_r_valid;
  logic [TAG_W-1:0] w_r_tag;
  logic [XLEN-1:0]  w_r_target;
  logic [1:0]       w_r_ctr;
  logic             w_u_valid;
  logic [TAG_W-1:0] w_u_tag;
  logic [1:0]       w_u_ctr;
  logic             w_f_hit;
  logic             w_e_hit;
  logic             w_res;
  logic             w_we;
  logic             w_wvalid;
  logic [TAG_W-1:0] w_wtag;
  logic             w_wtgt_en;
  logic [1:0]       w_wctr;
  logic [31:0]      r_mispred_cnt;
  logic             w_unused;

  assign w_f_idx  = PCF[IDX_W+1:2];
  assign w_f_tag  = PCF[XLEN-1:IDX_W+2];
  assign w_e_idx  = PCE[IDX_W+1:2];
  assign w_e_tag  = PCE[XLEN-1:IDX_W+2];
  assign w_unused = &{1'b0, PCE[1:0]};

  branch_predictor_btb_table #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .XLEN  (XLEN)
  ) u_btb_table (
    .clk       (CLK),
    .rst       (RST),
    .i_raddr   (w_f_idx),
    .o_rvalid  (w_r_valid),
    .o_rtag    (w_r_tag),
    .o_rtarget (w_r_target),
    .o_rctr    (w_r_ctr),
    .i_uaddr   (w_e_idx),
    .o_uvalid  (w_u_valid),
    .o_utag    (w_u_tag),
    .o_uctr    (w_u_ctr),
    .i_we      (w_we),
    .i_wvalid  (w_wvalid),
    .i_wtag    (w_wtag),
    .i_wtgt_en (w_wtgt_en),
    .i_wtarget (PCTargetE),
    .i_wctr    (w_wctr)
  );

  assign w_f_hit     = w_r_valid & (w_r_tag == w_f_tag);
  assign PredTakenF  = w_f_hit & w_r_ctr[1];
  assign PredTargetF = PredTakenF ? w_r_target : PCF + XLEN'(4);

  assign w_res       = ValidE & (BranchE | JumpE);
  assign w_e_hit     = w_u_valid & (w_u_tag == w_e_tag);
  assign MispredictE = ValidE & ((TakenE != PredTakenE) |
                                 (TakenE & PredTakenE & (PCTargetE != PredTargetE)));
  assign RedirectPCE = TakenE ? PCTargetE : PCPlus4E;

  // Default write-back re-stores the current entry so only the fields that change need overriding
  always_comb begin
    w_we      = 1'b0;
    w_wvalid  = w_u_valid;
    w_wtag    = w_u_tag;
    w_wctr    = w_u_ctr;
    w_wtgt_en = 1'b0;
    if (w_res) begin
      if (w_e_hit) begin
        w_we      = 1'b1;
        w_wctr    = JumpE ? 2'(ST) : ctr_next(w_u_ctr, TakenE);
        w_wtgt_en = TakenE;
      end else if (TakenE) begin
        w_we      = 1'b1;
        w_wvalid  = 1'b1;
        w_wtag    = w_e_tag;
        w_wctr    = JumpE ? 2'(ST) : 2'(WT);
        w_wtgt_en = 1'b1;
      end
    end else if (ValidE & PredTakenE & w_e_hit) begin
      // Non-control instruction predicted taken: drop the aliased entry
      w_we     = 1'b1;
      w_wvalid = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mispred_cnt <= '0;
    end else if (MispredictE && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign MispredCount = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================
// tb_branch_predictor : directed scoreboard bench for branch_predictor
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcf;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        valid_e, branch_e, jump_e, taken_e;
  logic [31:0] pc_e, pc_target_e, pc_plus4_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] mispred_count;

  branch_predictor #(.IDX_W(4), .XLEN(32)) dut (
    .CLK          (clk),
    .RST          (rst),
    .PCF          (pcf),
    .PredTakenF   (pred_taken_f),
    .PredTargetF  (pred_target_f),
    .ValidE       (valid_e),
    .BranchE      (branch_e),
    .JumpE        (jump_e),
    .TakenE       (taken_e),
    .PCE          (pc_e),
    .PCTargetE    (pc_target_e),
    .PCPlus4E     (pc_plus4_e),
    .PredTakenE   (pred_taken_e),
    .PredTargetE  (pred_target_e),
    .MispredictE  (mispredict_e),
    .RedirectPCE  (redirect_pc_e),
    .MispredCount (mispred_count)
  );

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL s%0d %s: got %h want %h", id, nm, act, exp);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.id, "pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e.pt});
        chk(e.id, "pred_target_f", pred_target_f, e.tgt);
        chk(e.id, "mispredict_e", {31'd0, mispredict_e}, {31'd0, e.mp});
        chk(e.id, "redirect_pc_e", redirect_pc_e, e.rd);
        chk(e.id, "mispred_count", mispred_count, e.cnt);
      end
    end
  end

  task automatic stp(input logic r, input logic [31:0] f, input logic ve, input logic be,
                     input logic je, input logic te, input logic [31:0] pce, input logic [31:0] tgt,
                     input logic [31:0] p4, input logic pte, input logic [31:0] ptg,
                     input logic x_pt, input logic [31:0] x_tgt, input logic x_mp,
                     input logic [31:0] x_rd, input logic [31:0] x_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pcf = f; valid_e = ve; branch_e = be; jump_e = je; taken_e = te;
    pc_e = pce; pc_target_e = tgt; pc_plus4_e = p4; pred_taken_e = pte; pred_target_e = ptg;
    step_id++;
    e.id = step_id; e.pt = x_pt; e.tgt = x_tgt; e.mp = x_mp; e.rd = x_rd; e.cnt = x_cnt;
    q.push_back(e);
  endtask

  task automatic idle(input logic r, input logic [31:0] f, input logic x_pt,
                      input logic [31:0] x_tgt, input logic [31:0] x_cnt);
    stp(r, f, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, x_pt, x_tgt, 0, 32'h0, x_cnt);
  endtask

  initial begin
    rst = 1; pcf = 0; valid_e = 0; branch_e = 0; jump_e = 0; taken_e = 0;
    pc_e = 0; pc_target_e = 0; pc_plus4_e = 0; pred_taken_e = 0; pred_target_e = 0;

    idle(1, 32'h100, 0, 32'h104, 0);
    idle(0, 32'h100, 0, 32'h104, 0);
    // allocate 0x100 taken; same-cycle lookup sees old (empty) entry
    stp(0, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0);
    idle(0, 32'h100, 1, 32'h80, 1);
    stp(0, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 32'h104, 1, 32'h80, 1, 32'h80, 1, 32'h104, 1);
    stp(0, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 0, 32'h104, 2);
    idle(0, 32'h100, 0, 32'h104, 2);
    // train back up from SNT
    stp(0, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 1, 32'h80, 2);
    stp(0, 32'h100, 1, 1, 0, 1, 32'h100, 32'h80, 32'h104, 0, 32'h104, 0, 32'h104, 1, 32'h80, 3);
    // alias 0x500 shares index 0
    idle(0, 32'h500, 0, 32'h504, 4);
    idle(0, 32'h100, 1, 32'h80, 4);
    stp(0, 32'h500, 1, 1, 0, 1, 32'h500, 32'h600, 32'h504, 0, 32'h504, 0, 32'h504, 1, 32'h600, 4);
    idle(0, 32'h100, 0, 32'h104, 5);
    idle(0, 32'h500, 1, 32'h600, 5);
    // jalr at 0x200: wrong target, allocates with ST
    stp(0, 32'h200, 1, 0, 1, 1, 32'h200, 32'h340, 32'h204, 1, 32'h300, 0, 32'h204, 1, 32'h340, 5);
    idle(0, 32'h200, 1, 32'h340, 6);
    stp(0, 32'h200, 1, 0, 1, 1, 32'h200, 32'h380, 32'h204, 1, 32'h340, 1, 32'h340, 1, 32'h380, 6);
    idle(0, 32'h200, 1, 32'h380, 7);
    stp(0, 32'h200, 1, 0, 1, 1, 32'h200, 32'h380, 32'h204, 1, 32'h380, 1, 32'h380, 0, 32'h380, 7);
    // bubble with BranchE=1 must not allocate 0x240 over 0x200
    stp(0, 32'h200, 0, 1, 0, 1, 32'h240, 32'h900, 32'h244, 0, 32'h244, 1, 32'h380, 0, 32'h900, 7);
    idle(0, 32'h200, 1, 32'h380, 7);
    // stale alias: non-branch predicted taken invalidates entry
    stp(0, 32'h200, 1, 0, 0, 0, 32'h200, 32'h0, 32'h204, 1, 32'h380, 1, 32'h380, 1, 32'h204, 7);
    idle(0, 32'h200, 0, 32'h204, 8);
    idle(0, 32'hFFFF_FFFC, 0, 32'h0, 8);
    stp(0, 32'h300, 1, 0, 1, 1, 32'h300, 32'h10, 32'h304, 0, 32'h304, 0, 32'h304, 1, 32'h10, 8);
    idle(0, 32'h300, 1, 32'h10, 9);
    // reset mid-run with an update in flight
    stp(1, 32'h300, 1, 1, 0, 1, 32'h140, 32'h44, 32'h144, 0, 32'h144, 0, 32'h304, 1, 32'h44, 0);
    idle(1, 32'h140, 0, 32'h144, 0);
    idle(0, 32'h140, 0, 32'h144, 0);
    idle(0, 32'h300, 0, 32'h304, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    stim_done = 1;
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
    end
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the Execute-stage branch resolution logic.
- Fetch: predicts taken/not-taken and the target for the instruction at PCF.
- Execute: receives the resolved outcome, trains its tables, and flags mispredictions so the hazard unit can flush F/D and redirect the PC.
- Structure: direct-mapped BTB plus a 2-bit saturating counter per entry.

Parameters:
- IDX_W, 4, index bits; table has 2**IDX_W entries.
- XLEN, 32, address width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- PCF  input  XLEN  Fetch PC.
- PredTakenF  output  1  predicted taken for PCF.
- PredTargetF  output  XLEN  predicted target; equals PCF+4 when PredTakenF=0.
- ValidE  input  1  Execute slot holds a real instruction (0 when flushed/bubble).
- BranchE  input  1  conditional branch in Execute.
- JumpE  input  1  jal/jalr in Execute.
- TakenE  input  1  resolved outcome (PCSrcE).
- PCE  input  XLEN  Execute PC.
- PCTargetE  input  XLEN  resolved target.
- PCPlus4E  input  XLEN  fall-through PC.
- PredTakenE  input  1  PredTakenF piped to Execute.
- PredTargetE  input  XLEN  PredTargetF piped to Execute.
- MispredictE  output  1  combinational misprediction flag.
- RedirectPCE  output  XLEN  correct next PC when MispredictE=1.
- MispredCount  output  32  saturating misprediction counter.

Behaviour:
- Addressing:
  - index = PC[IDX_W+1:2]
  - tag = PC[XLEN-1:IDX_W+2]
  - Per entry: Valid, Tag, Target[XLEN-1:0], Ctr[1:0].
- Lookup, combinational, 0-cycle:
  - hit = Valid[index] & (Tag == tag(PCF)).
  - PredTakenF = hit & Ctr[1].
  - PredTargetF = PredTakenF ? Target : PCF+4.
- Resolution, combinational:
  - res = ValidE & (BranchE | JumpE).
  - MispredictE = ValidE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & (PCTargetE != PredTargetE))).
  - A non-branch instruction predicted taken (stale alias) counts as a misprediction with TakenE=0.
  - RedirectPCE = TakenE ? PCTargetE : PCPlus4E.
- Update, on the clock edge when res=1, at index(PCE):
  - Entry hit and TakenE=1: Ctr increments (saturates at 11); Target <= PCTargetE.
  - Entry hit and TakenE=0: Ctr decrements (saturates at 00); Target unchanged.
  - Entry miss and TakenE=1: allocate. Valid <= 1, Tag <= tag(PCE), Target <= PCTargetE, Ctr <= 10 (JumpE: 11).
  - Entry miss and TakenE=0: no change.
  - JumpE on hit: Ctr <= 11.
- Stale alias, ValidE=1 with BranchE=JumpE=0 and PredTakenE=1: entry at index(PCE) is invalidated if its tag matches.
- ValidE=0: no update, MispredictE=0.
- MispredCount:
  - Increments on every cycle MispredictE=1.
  - Holds at 32'hFFFF_FFFF.
- Same-cycle read and write to the same index: lookup returns the pre-update contents; no bypass.
- Reset:
  - All Valid = 0, all Ctr = 01, Target/Tag = 0, MispredCount = 0.
  - During and immediately after reset, PredTakenF = 0 and PredTargetF = PCF+4.
  - Asynchronous assertion mid-operation discards any in-flight update.
- Width rules: all PC arithmetic is modulo 2**XLEN; PCF+4 wraps at 32'hFFFF_FFFC -> 0.

Decomposition:
- Shared package:
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - Default IDX_W.
  - Function computing saturating counter next-state from (ctr, taken).
- One sub-module: btb_table. Holds the register arrays, async reset, one combinational read port and one write port.
- Predict/resolve/counter logic stays in the top.

Test Plan:
- Reset then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, MispredCount=0.
- Branch at PCE=0x100, TakenE=1, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80, MispredCount=1.
- Same branch resolved not-taken twice -> Ctr 10->01->00. PCF=0x100 -> PredTakenF=0; second resolution (PredTakenE=0) gives MispredictE=0.
- Aliasing, IDX_W=4:
  - Allocate 0x100 taken.
  - PCF=0x500 (same index, different tag) -> PredTakenF=0.
  - Allocate 0x500 taken -> 0x100 now misses.
- Jalr at 0x200: PredTargetE=0x300, PCTargetE=0x340, both taken -> MispredictE=1, RedirectPCE=0x340, Target updated to 0x340.
- Update and lookup on the same index in one cycle -> old prediction seen. ValidE=0 with BranchE=1 -> no table change, MispredictE=0. RST pulsed mid-run -> all predictions cleared, counter 0.
